// File: rtl/pq_access_arbiter.sv
// pq_access_arbiter
//   Shares one systolic min-priority queue among NUM_REQ requesters. One
//   enqueue winner and one dequeue winner are picked per issue slot by two
//   independent round-robin arbiters and merged into the queue's single-cycle
//   write/read strobes. After every issued operation the block idles for
//   SETTLE_CYCLES cycles so the queue head can re-sort before it is sampled
//   again.
//
//   Handshakes: an enqueue transfers in the cycle where i_enq_valid[r] and
//   o_enq_ready[r] are both high (ready is a one-hot, combinational accept
//   pulse). A dequeue is granted by a one-hot o_deq_grant pulse in the issue
//   cycle; the popped value returns one cycle later on o_deq_valid/o_deq_data
//   tagged with o_deq_id. Requests are levels and simply wait while o_busy.
//
// Ports
//   CLK, RSTn     clock, asynchronous active-low reset
//   i_enq_valid   per-requester enqueue request
//   i_enq_data    packed enqueue values, requester r at [r*DATA_WIDTH +: DATA_WIDTH]
//   o_enq_ready   one-hot enqueue accept pulse
//   i_deq_req     per-requester dequeue request
//   o_deq_grant   one-hot dequeue grant pulse
//   o_deq_valid   response pulse, one cycle after the grant
//   o_deq_data    popped value
//   o_deq_id      requester index of the response
//   o_busy        high while settling
//   o_q_wrt       queue enqueue strobe
//   o_q_read      queue dequeue strobe
//   o_q_node_f    queue write data
//   i_q_full      queue full flag
//   i_q_empty     queue empty flag
//   i_q_node_f    queue head value
module pq_access_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                          CLK,
   input  logic                          RSTn,
   input  logic [NUM_REQ-1:0]            i_enq_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_enq_data,
   output logic [NUM_REQ-1:0]            o_enq_ready,
   input  logic [NUM_REQ-1:0]            i_deq_req,
   output logic [NUM_REQ-1:0]            o_deq_grant,
   output logic                          o_deq_valid,
   output logic [DATA_WIDTH-1:0]         o_deq_data,
   output logic [$clog2(NUM_REQ)-1:0]    o_deq_id,
   output logic                          o_busy,
   output logic                          o_q_wrt,
   output logic                          o_q_read,
   output logic [DATA_WIDTH-1:0]         o_q_node_f,
   input  logic                          i_q_full,
   input  logic                          i_q_empty,
   input  logic [DATA_WIDTH-1:0]         i_q_node_f
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
   localparam logic HAS_SETTLE = (SETTLE_CYCLES > 0);

   typedef enum logic {ST_ARB = 1'b0, ST_SETTLE = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        enq_ptr_q, enq_ptr_d;
   logic [ID_W-1:0]        deq_ptr_q, deq_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   deq_valid_q, deq_valid_d;
   logic [DATA_WIDTH-1:0]  deq_data_q, deq_data_d;
   logic [ID_W-1:0]        deq_id_q, deq_id_d;

   logic                   enq_found, deq_found;
   logic [ID_W-1:0]        enq_idx, deq_idx;
   logic [ID_W-1:0]        cand_e, cand_d;
   logic                   arb_ok, enq_win, deq_win, issue;

   // Round-robin search starting at each pointer; first hit wins.
   always_comb begin
      enq_found = 1'b0;
      enq_idx   = '0;
      deq_found = 1'b0;
      deq_idx   = '0;
      cand_e    = '0;
      cand_d    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_e = ID_W'((int'(enq_ptr_q) + k) % NUM_REQ);
         cand_d = ID_W'((int'(deq_ptr_q) + k) % NUM_REQ);
         if (!enq_found && i_enq_valid[cand_e]) begin
            enq_found = 1'b1;
            enq_idx   = cand_e;
         end
         if (!deq_found && i_deq_req[cand_d]) begin
            deq_found = 1'b1;
            deq_idx   = cand_d;
         end
      end
   end

   // Outputs are gated by RSTn so nothing strobes while reset is held.
   // A dequeue on an empty queue is never granted, even alongside an
   // enqueue; a full queue still accepts an enqueue when it is a replace.
   assign arb_ok  = RSTn && (state_q == ST_ARB);
   assign deq_win = arb_ok && deq_found && !i_q_empty;
   assign enq_win = arb_ok && enq_found && (!i_q_full || deq_win);
   assign issue   = enq_win || deq_win;

   always_comb begin
      o_enq_ready = '0;
      o_deq_grant = '0;
      o_q_node_f  = '0;
      if (enq_win) o_enq_ready = NUM_REQ'(1) << enq_idx;
      if (deq_win) o_deq_grant = NUM_REQ'(1) << deq_idx;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (enq_win && (enq_idx == ID_W'(r))) begin
            o_q_node_f = i_enq_data[r*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign o_q_wrt  = enq_win;
   assign o_q_read = deq_win;
   assign o_busy   = RSTn && (state_q == ST_SETTLE);

   // Next-state: FSM, settle counter, pointers, response capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      enq_ptr_d   = enq_ptr_q;
      deq_ptr_d   = deq_ptr_q;
      deq_valid_d = deq_win;
      deq_data_d  = deq_data_q;
      deq_id_d    = deq_id_q;

      case (state_q)
         ST_ARB: begin
            if (issue && HAS_SETTLE) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_ARB;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = ST_ARB;
      endcase

      if (enq_win) begin
         enq_ptr_d = (enq_idx == ID_W'(NUM_REQ - 1)) ? '0 : enq_idx + ID_W'(1);
      end
      if (deq_win) begin
         deq_ptr_d  = (deq_idx == ID_W'(NUM_REQ - 1)) ? '0 : deq_idx + ID_W'(1);
         // Head is sampled in the issue cycle, before the queue shifts.
         deq_data_d = i_q_node_f;
         deq_id_d   = deq_idx;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= ST_ARB;
         cnt_q       <= '0;
         enq_ptr_q   <= '0;
         deq_ptr_q   <= '0;
         deq_valid_q <= 1'b0;
         deq_data_q  <= '0;
         deq_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         enq_ptr_q   <= enq_ptr_d;
         deq_ptr_q   <= deq_ptr_d;
         deq_valid_q <= deq_valid_d;
         deq_data_q  <= deq_data_d;
         deq_id_q    <= deq_id_d;
      end
   end

   assign o_deq_valid = deq_valid_q;
   assign o_deq_data  = deq_data_q;
   assign o_deq_id    = deq_id_q;

endmodule

// File: tb/tb_pq_access_arbiter.sv
// tb_pq_access_arbiter
//   Three instances of pq_access_arbiter share one set of stimulus inputs,
//   built with SETTLE_CYCLES = 1, 0 and 3. Each scenario resets all of them
//   and checks only the instance whose settle length it targets.
module tb_pq_access_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int IW = 2;
   localparam int SW = IW + DW;

   logic           CLK;
   logic           RSTn;
   logic [NR-1:0]  enq_valid;
   logic [NR*DW-1:0] enq_data;
   logic [NR-1:0]  deq_req;
   logic           q_full;
   logic           q_empty;
   logic [DW-1:0]  q_node;

   logic [NR-1:0] s1_enq_ready, s1_deq_grant, s0_enq_ready, s0_deq_grant, s3_enq_ready, s3_deq_grant;
   logic          s1_deq_valid, s1_busy, s1_q_wrt, s1_q_read;
   logic          s0_deq_valid, s0_busy, s0_q_wrt, s0_q_read;
   logic          s3_deq_valid, s3_busy, s3_q_wrt, s3_q_read;
   logic [DW-1:0] s1_deq_data, s1_q_node, s0_deq_data, s0_q_node, s3_deq_data, s3_q_node;
   logic [IW-1:0] s1_deq_id, s0_deq_id, s3_deq_id;

   int n_tests;
   int n_fail;
   logic [SW-1:0] exp_q[$];

   pq_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(1)) u_s1 (
      .CLK(CLK), .RSTn(RSTn),
      .i_enq_valid(enq_valid), .i_enq_data(enq_data), .o_enq_ready(s1_enq_ready),
      .i_deq_req(deq_req), .o_deq_grant(s1_deq_grant),
      .o_deq_valid(s1_deq_valid), .o_deq_data(s1_deq_data), .o_deq_id(s1_deq_id),
      .o_busy(s1_busy), .o_q_wrt(s1_q_wrt), .o_q_read(s1_q_read), .o_q_node_f(s1_q_node),
      .i_q_full(q_full), .i_q_empty(q_empty), .i_q_node_f(q_node)
   );

   pq_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(0)) u_s0 (
      .CLK(CLK), .RSTn(RSTn),
      .i_enq_valid(enq_valid), .i_enq_data(enq_data), .o_enq_ready(s0_enq_ready),
      .i_deq_req(deq_req), .o_deq_grant(s0_deq_grant),
      .o_deq_valid(s0_deq_valid), .o_deq_data(s0_deq_data), .o_deq_id(s0_deq_id),
      .o_busy(s0_busy), .o_q_wrt(s0_q_wrt), .o_q_read(s0_q_read), .o_q_node_f(s0_q_node),
      .i_q_full(q_full), .i_q_empty(q_empty), .i_q_node_f(q_node)
   );

   pq_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .SETTLE_CYCLES(3)) u_s3 (
      .CLK(CLK), .RSTn(RSTn),
      .i_enq_valid(enq_valid), .i_enq_data(enq_data), .o_enq_ready(s3_enq_ready),
      .i_deq_req(deq_req), .o_deq_grant(s3_deq_grant),
      .o_deq_valid(s3_deq_valid), .o_deq_data(s3_deq_data), .o_deq_id(s3_deq_id),
      .o_busy(s3_busy), .o_q_wrt(s3_q_wrt), .o_q_read(s3_q_read), .o_q_node_f(s3_q_node),
      .i_q_full(q_full), .i_q_empty(q_empty), .i_q_node_f(q_node)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      enq_valid = '0;
      deq_req   = '0;
      q_full    = 1'b0;
      q_empty   = 1'b1;
      q_node    = '0;
      for (int r = 0; r < NR; r++) enq_data[r*DW +: DW] = DW'($urandom_range(0, 16'hffff));
   endtask

   task automatic set_slot(input int r, input logic [DW-1:0] v);
      enq_data[r*DW +: DW] = v;
   endtask

   task automatic apply_reset();
      RSTn = 1'b0;
      idle_inputs();
      tick();
      tick();
      RSTn = 1'b1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard entry is {requester id, data}.
   task automatic sb_pop(input string tag, output logic [SW-1:0] e, output logic ok);
      check({tag, "_avail"}, 32'(exp_q.size() != 0), 32'd1);
      ok = (exp_q.size() != 0);
      e  = '0;
      if (ok) e = exp_q.pop_front();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [SW-1:0] e;
      logic          ok;
      int            lat;
      logic [DW-1:0] rnd;
      n_tests = 0;
      n_fail  = 0;

      // Reset state: requests active while reset held must produce nothing.
      RSTn = 1'b0;
      idle_inputs();
      tick();
      enq_valid = 4'hf;
      deq_req   = 4'hf;
      q_empty   = 1'b0;
      #1;
      check("rst_enq_ready", 32'(s1_enq_ready), 32'h0);
      check("rst_deq_grant", 32'(s1_deq_grant), 32'h0);
      check("rst_q_wrt",     32'(s1_q_wrt),     32'h0);
      check("rst_q_read",    32'(s1_q_read),    32'h0);
      check("rst_deq_valid", 32'(s1_deq_valid), 32'h0);
      check("rst_busy",      32'(s1_busy),      32'h0);

      // 1. Single enqueue, SETTLE_CYCLES=1.
      apply_reset();
      enq_valid = 4'b0100;
      set_slot(2, 16'h0040);
      #1;
      check("t1_q_wrt",     32'(s1_q_wrt),     32'h1);
      check("t1_q_node",    32'(s1_q_node),    32'h40);
      check("t1_enq_ready", 32'(s1_enq_ready), 32'h4);
      check("t1_q_read",    32'(s1_q_read),    32'h0);
      tick();
      enq_valid = '0;
      #1;
      check("t1_busy_settle", 32'(s1_busy), 32'h1);
      tick();
      check("t1_busy_arb",  32'(s1_busy), 32'h0);

      // 2. Enqueue fairness, SETTLE_CYCLES=0.
      apply_reset();
      enq_valid = 4'hf;
      for (int r = 0; r < NR; r++) set_slot(r, DW'((r + 1) * 10));
      for (int i = 0; i < 5; i++) exp_q.push_back({IW'(i % NR), DW'(((i % NR) + 1) * 10)});
      #1;
      for (int i = 0; i < 5; i++) begin
         check("t2_q_wrt", 32'(s0_q_wrt), 32'h1);
         sb_pop("t2", e, ok);
         if (ok) begin
            check("t2_enq_ready", 32'(s0_enq_ready), 32'(4'b0001 << e[SW-1:DW]));
            check("t2_q_node",    32'(s0_q_node),    32'(e[DW-1:0]));
         end
         tick();
      end
      enq_valid = '0;

      // 3. Dequeue response.
      apply_reset();
      q_empty = 1'b0;
      q_node  = 16'h0005;
      deq_req = 4'b1000;
      exp_q.push_back({IW'(3), 16'h0005});
      #1;
      check("t3_deq_grant", 32'(s1_deq_grant), 32'h8);
      check("t3_q_read",    32'(s1_q_read),    32'h1);
      check("t3_q_wrt",     32'(s1_q_wrt),     32'h0);
      tick();
      deq_req = '0;
      rnd     = DW'($urandom_range(16'h0100, 16'hffff));
      q_node  = rnd;  // head changes after the pop; must not be captured
      #1;
      lat = 1;
      while (!s1_deq_valid && lat < 4) begin
         tick();
         lat++;
      end
      check("t3_deq_valid", 32'(s1_deq_valid), 32'h1);
      check("t3_latency",   32'(lat),          32'd1);
      sb_pop("t3", e, ok);
      if (ok) begin
         check("t3_deq_id",   32'(s1_deq_id),   32'(e[SW-1:DW]));
         check("t3_deq_data", 32'(s1_deq_data), 32'(e[DW-1:0]));
      end
      tick();
      check("t3_valid_pulse", 32'(s1_deq_valid), 32'h0);

      // 4. Simultaneous ops, replace on full, held enqueue on full.
      apply_reset();
      q_empty   = 1'b0;
      q_node    = 16'h0003;
      enq_valid = 4'b0001;
      set_slot(0, 16'd7);
      deq_req   = 4'b0010;
      #1;
      check("t4_q_wrt",     32'(s1_q_wrt),     32'h1);
      check("t4_q_read",    32'(s1_q_read),    32'h1);
      check("t4_q_node",    32'(s1_q_node),    32'd7);
      check("t4_enq_ready", 32'(s1_enq_ready), 32'h1);
      check("t4_deq_grant", 32'(s1_deq_grant), 32'h2);
      tick();
      tick();
      q_full = 1'b1;
      #1;
      check("t4_full_q_wrt",  32'(s1_q_wrt),  32'h1);
      check("t4_full_q_read", 32'(s1_q_read), 32'h1);
      tick();
      tick();
      deq_req = '0;
      #1;
      check("t4_hold_enq_ready", 32'(s1_enq_ready), 32'h0);
      check("t4_hold_q_wrt",     32'(s1_q_wrt),     32'h0);
      check("t4_hold_busy",      32'(s1_busy),      32'h0);

      // 5a. Empty queue: only the enqueue issues.
      apply_reset();
      q_empty   = 1'b1;
      deq_req   = 4'b0010;
      enq_valid = 4'b0001;
      set_slot(0, 16'd9);
      #1;
      check("t5_q_wrt",     32'(s1_q_wrt),     32'h1);
      check("t5_q_node",    32'(s1_q_node),    32'd9);
      check("t5_q_read",    32'(s1_q_read),    32'h0);
      check("t5_deq_grant", 32'(s1_deq_grant), 32'h0);
      tick();
      tick();
      check("t5_no_resp",   32'(s1_deq_valid), 32'h0);

      // 5b. SETTLE_CYCLES=3: three silent cycles after an issue.
      apply_reset();
      q_empty   = 1'b0;
      enq_valid = 4'b0001;
      set_slot(0, 16'd9);
      #1;
      check("t5s_issue", 32'(s3_q_wrt), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5s_quiet_wrt",  32'(s3_q_wrt),     32'h0);
         check("t5s_quiet_rdy",  32'(s3_enq_ready), 32'h0);
         check("t5s_quiet_busy", 32'(s3_busy),      32'h1);
      end
      tick();
      check("t5s_reissue",  32'(s3_q_wrt), 32'h1);
      check("t5s_arb_busy", 32'(s3_busy),  32'h0);

      // 6. Reset mid-SETTLE with a response pending.
      apply_reset();
      q_empty   = 1'b0;
      q_node    = 16'h0055;
      deq_req   = 4'b0100;
      enq_valid = 4'b0001;
      #1;
      check("t6_issue", 32'(s1_q_read), 32'h1);
      tick();
      check("t6_pending", 32'(s1_deq_valid), 32'h1);
      RSTn = 1'b0;
      #1;
      check("t6_rst_deq_valid", 32'(s1_deq_valid), 32'h0);
      check("t6_rst_deq_data",  32'(s1_deq_data),  32'h0);
      check("t6_rst_deq_id",    32'(s1_deq_id),    32'h0);
      check("t6_rst_busy",      32'(s1_busy),      32'h0);
      check("t6_rst_grant",     32'(s1_deq_grant), 32'h0);
      check("t6_rst_ready",     32'(s1_enq_ready), 32'h0);
      #2;
      RSTn      = 1'b1;
      deq_req   = 4'hf;
      enq_valid = 4'hf;
      #1;
      check("t6_arb_grant", 32'(s1_deq_grant), 32'h1);
      check("t6_arb_ready", 32'(s1_enq_ready), 32'h1);
      check("t6_arb_busy",  32'(s1_busy),      32'h0);
      tick();
      check("t6_no_resp_lost", 32'(s1_deq_id), 32'h0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pq_access_arbiter.md
Name: pq_access_arbiter

Overview:
Shares one systolic min-priority queue among NUM_REQ requesters. Each requester has an enqueue channel (valid/ready) and a dequeue channel (request/grant, tagged response). The block picks one enqueue and one dequeue winner per issue slot using independent round-robin arbiters. It merges them into the queue's single-cycle write/read/replace strobes. After every issued operation it holds off further strobes for SETTLE_CYCLES so that the queue's head (output buffer position 0) re-sorts before it is sampled again.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 16, node value width; must match the queue
SETTLE_CYCLES, 1, idle cycles forced after each issued op (0 allowed = back-to-back issue)

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
i_enq_valid  in  NUM_REQ  per-requester enqueue request
i_enq_data  in  NUM_REQ*DATA_WIDTH  packed enqueue values; requester r at [r*DATA_WIDTH +: DATA_WIDTH]
o_enq_ready  out  NUM_REQ  one-hot accept pulse; the transfer occurs when valid&ready
i_deq_req  in  NUM_REQ  per-requester dequeue request (level)
o_deq_grant  out  NUM_REQ  one-hot grant pulse in the issue cycle
o_deq_valid  out  1  response pulse, one cycle after the grant
o_deq_data  out  DATA_WIDTH  popped value, qualified by o_deq_valid
o_deq_id  out  $clog2(NUM_REQ)  requester index of the response
o_busy  out  1  high while in SETTLE
o_q_wrt  out  1  queue enqueue strobe
o_q_read  out  1  queue dequeue strobe
o_q_node_f  out  DATA_WIDTH  queue write data
i_q_full  in  1  queue full flag
i_q_empty  in  1  queue empty flag
i_q_node_f  in  DATA_WIDTH  queue head value

Behaviour:
- Reset values: state=ARB; enq and deq RR pointers=0; settle counter=0; o_deq_valid=0; o_deq_data=0; o_deq_id=0.
- Reset effects: all combinational outputs are 0 while RSTn is low. Reset asserted mid-SETTLE or with a response pending clears everything, and the pending response is dropped.
- FSM has two states, ARB and SETTLE.
- ARB decisions (combinational, same cycle):
  - deq_win: requester with i_deq_req, searched round-robin from the deq pointer. A deq_win exists only if !i_q_empty.
  - enq_win: requester with i_enq_valid, searched round-robin from the enq pointer.
  - enq_win exists if !i_q_full, or if i_q_full and a deq_win exists in the same cycle (replace on a full queue).
  - Queue drive: o_q_wrt = enq_win exists; o_q_read = deq_win exists; o_q_node_f = the winner's data, else 0.
  - Handshake outputs: o_enq_ready[enq_win]=1; o_deq_grant[deq_win]=1.
- Empty-queue rule: a dequeue is never granted when the queue is empty. This holds even if an enqueue issues in the same cycle, so the queue's "write+read while empty" path is never exercised.
- Response capture (registered): on a deq grant, i_q_node_f sampled in the issue cycle is loaded into o_deq_data, and the winner index into o_deq_id. o_deq_valid=1 in the next cycle only. Latency from grant to response is 1 cycle.
- Pointer update: each pointer becomes (winner+1) mod NUM_REQ only when that channel grants; otherwise it holds. The two pointers are independent.
- Transitions:
  - If any strobe issues and SETTLE_CYCLES>0: go to SETTLE and load counter=SETTLE_CYCLES-1.
  - If SETTLE_CYCLES==0: stay in ARB.
  - If nothing issues: stay in ARB.
- SETTLE state: all strobes, readys and grants are 0 and o_busy=1. When counter==0, go to ARB; else decrement.
- Requester rules:
  - i_enq_data may change freely while not accepted.
  - A requester may hold i_enq_valid and i_deq_req together; the two channels arbitrate independently.
  - Requests arriving during SETTLE wait; nothing is lost, since requests are levels.
- Flag sampling: i_q_full and i_q_empty are sampled combinationally in the ARB cycle. No internal occupancy counter is kept.

Test Plan:
1. Single enqueue: from reset, SETTLE_CYCLES=1, requester 2 enqueues 0x0040 -> o_q_wrt=1 and o_q_node_f=0x0040 in that cycle; o_enq_ready=4'b0100; o_busy=1 next cycle; ARB the cycle after.
2. Enqueue fairness: all 4 requesters hold i_enq_valid (values 10, 20, 30, 40), SETTLE_CYCLES=0 -> accept order 0,1,2,3,0 on consecutive cycles; no requester is starved.
3. Dequeue response: queue head=0x0005, requester 3 requests -> o_deq_grant=4'b1000 and o_q_read=1; next cycle o_deq_valid=1, o_deq_data=0x0005, o_deq_id=3.
4. Simultaneous ops: requester 0 enqueues 7 while requester 1 dequeues on a non-empty queue -> o_q_wrt=o_q_read=1 in the same cycle. With i_q_full=1 the same replace still issues. With i_q_full=1 and no dequeue pending, the enqueue is held (o_enq_ready=0).
5. Empty and settle: i_q_empty=1, requester 1 requests dequeue and requester 0 enqueues 9 -> only the enqueue issues and the grant stays 0. Then, with SETTLE_CYCLES=3, no strobe appears for 3 cycles after an issue.
6. Reset mid-op: assert RSTn low during SETTLE with a response pending -> all outputs go to 0 at once; after release the state is ARB and both pointers are 0.
